// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared types and constants for the register-file controller:
//   op_e     - request opcodes (NOP, WRITE, READ, reserved)
//   ERR_*    - response error codes
//   state_e  - controller FSM states
//   rdsel_e  - source of the response read data
//   classify - error classification of a captured request
// -----------------------------------------------------------------------------
package reg_file_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    localparam logic [3:0] ERR_OK     = 4'd0;
    localparam logic [3:0] ERR_ADDR   = 4'd1;
    localparam logic [3:0] ERR_OPCODE = 4'd2;
    localparam logic [3:0] ERR_RO     = 4'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RD_ZERO  = 2'd0,
        RD_ID    = 2'd1,
        RD_ARRAY = 2'd2
    } rdsel_e;

    // Priority: bad opcode beats bad address beats read-only write.
    function automatic logic [3:0] classify(input op_e op, input logic addr_ok,
                                            input logic addr_ro);
        if (op == OP_RSVD)
            return ERR_OPCODE;
        if (!addr_ok)
            return ERR_ADDR;
        if (op == OP_WRITE && addr_ro)
            return ERR_RO;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/reg_file_array.sv
// -----------------------------------------------------------------------------
// reg_file_array
// DEPTH x DATA_W register storage with byte-enable write and a registered
// read port (read data appears the cycle after re, and holds until the next re).
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-low reset; clears every entry and rdata
//   we     - write enable (bytes selected by wstrb)
//   re     - read enable
//   addr   - entry index (accesses at or beyond DEPTH are ignored)
//   wdata  - write data
//   wstrb  - byte enables
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module reg_file_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] mask;
    logic              in_range;

    assign in_range = 32'(addr) < DEPTH;

    for (genvar b = 0; b < DATA_W/8; b++) begin : g_mask
        assign mask[b*8 +: 8] = {8{wstrb[b]}};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem   <= '{default: '0};
            rdata <= '0;
        end else begin
            if (we && in_range)
                mem[addr] <= (mem[addr] & ~mask) | (wdata & mask);
            if (re && in_range)
                rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl
// Request/response register-file controller. One request is accepted in IDLE,
// the storage is accessed for exactly one cycle in ACCESS, and the response is
// presented in RESP until the consumer takes it.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-low reset
//   req_valid  - request present
//   req_ready  - controller can accept a request (IDLE only)
//   req_op     - 00 NOP, 01 WRITE, 10 READ, 11 reserved
//   req_addr   - register address
//   req_wdata  - write data
//   req_wstrb  - byte enables for WRITE
//   rsp_valid  - response present
//   rsp_ready  - consumer accepts response
//   rsp_rdata  - read data (0 for errors, WRITE and NOP)
//   rsp_error  - 0 OK, 1 bad address, 2 bad opcode, 3 read-only write
//   err_count  - saturating count of error responses handed off
// -----------------------------------------------------------------------------
module reg_file_ctrl
    import reg_file_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 255,
    parameter int                RO_COUNT = 1,
    parameter logic [DATA_W-1:0] ID_VALUE = 32'hACC0_0001
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [3:0]            rsp_error,
    output logic [7:0]            err_count
);

    state_e                state;
    state_e                state_nxt;

    op_e                   op_p0;
    logic [ADDR_W-1:0]     addr_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic [DATA_W/8-1:0]   wstrb_p0;

    logic                  addr_ok;
    logic                  addr_ro;
    logic [3:0]            err_p0;

    logic [3:0]            err_p1;
    rdsel_e                rdsel_p1;

    logic                  arr_we;
    logic                  arr_re;
    logic [DATA_W-1:0]     arr_rdata;

    logic                  accept;
    logic                  rsp_hs;

    assign accept = req_valid && req_ready;
    assign rsp_hs = rsp_valid && rsp_ready;

    // ---- p0: request capture (IDLE -> ACCESS) ----
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0    <= op_e'(req_op);
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
            wstrb_p0 <= req_wstrb;
        end
    end

    assign addr_ok = 32'(addr_p0) < DEPTH;
    assign addr_ro = 32'(addr_p0) < RO_COUNT;
    assign err_p0  = classify(op_p0, addr_ok, addr_ro);

    // ---- p1: response result capture (ACCESS -> RESP) ----
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_p1   <= ERR_OK;
            rdsel_p1 <= RD_ZERO;
        end else if (state == ST_ACCESS) begin
            err_p1 <= err_p0;
            if (err_p0 != ERR_OK || op_p0 != OP_READ)
                rdsel_p1 <= RD_ZERO;
            else if (addr_p0 == '0)
                rdsel_p1 <= RD_ID;
            else if (addr_ro)
                rdsel_p1 <= RD_ZERO;
            else
                rdsel_p1 <= RD_ARRAY;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = ST_RESP;
            ST_RESP:   if (rsp_hs) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs. req_ready is gated by reset so it is low during reset
    // even though the state register already reads IDLE.
    always_comb begin
        req_ready = reset && (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        arr_we    = (state == ST_ACCESS) && (op_p0 == OP_WRITE) && (err_p0 == ERR_OK);
        arr_re    = (state == ST_ACCESS) && (op_p0 == OP_READ) && (err_p0 == ERR_OK) && !addr_ro;
        rsp_error = ERR_OK;
        rsp_rdata = '0;
        if (state == ST_RESP) begin
            rsp_error = err_p1;
            case (rdsel_p1)
                RD_ID:    rsp_rdata = ID_VALUE;
                RD_ARRAY: rsp_rdata = arr_rdata;
                default:  rsp_rdata = '0;
            endcase
        end
    end

    // Counts errors when the response is actually handed off, not when produced.
    always_ff @(posedge clk) begin
        if (!reset)
            err_count <= 8'd0;
        else if (rsp_hs && rsp_error != ERR_OK && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end

    reg_file_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_p0),
        .wdata (wdata_p0),
        .wstrb (wstrb_p0),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_reg_file_ctrl.sv
module tb_reg_file_ctrl;

    localparam int          DEPTH    = 255;
    localparam int          RO_COUNT = 1;
    localparam logic [31:0] ID_VAL   = 32'hACC0_0001;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [3:0]  rsp_error;
    logic [7:0]  err_count;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] mdl [256];
    int          mdl_errcnt;

    logic [31:0] last_rdata;
    logic [3:0]  last_err;

    reg_file_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mdl[i] = 32'h0;
        mdl_errcnt = 0;
    endtask

    // One full transaction: accept, latency check, optional stall, handshake.
    task automatic do_req(input logic [1:0] op, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int stall);
        logic [31:0] exp_rdata;
        logic [3:0]  exp_err;
        int          waitc;

        if (op == 2'b11)                          exp_err = 4'd2;
        else if (int'(addr) >= DEPTH)             exp_err = 4'd1;
        else if (op == 2'b01 && int'(addr) < RO_COUNT) exp_err = 4'd3;
        else                                      exp_err = 4'd0;

        exp_rdata = 32'h0;
        if (exp_err == 4'd0 && op == 2'b10) begin
            if (addr == 8'd0)                 exp_rdata = ID_VAL;
            else if (int'(addr) < RO_COUNT)   exp_rdata = 32'h0;
            else                              exp_rdata = mdl[addr];
        end

        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        waitc = 0;
        while (req_ready !== 1'b1 && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);

        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rsp_valid_n1", {31'b0, rsp_valid}, 32'd0);

        @(posedge clk); #1;
        check("rsp_valid_n2", {31'b0, rsp_valid}, 32'd1);
        check("rsp_rdata",    rsp_rdata, exp_rdata);
        check("rsp_error",    {28'b0, rsp_error}, {28'b0, exp_err});
        last_rdata = rsp_rdata;
        last_err   = rsp_error;

        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            req_valid = 1'b1;
            req_op    = 2'b10;
            req_addr  = 8'd1;
            @(posedge clk); #1;
            check("stall_valid", {31'b0, rsp_valid}, 32'd1);
            check("stall_rdata", rsp_rdata, exp_rdata);
            check("stall_error", {28'b0, rsp_error}, {28'b0, exp_err});
            check("stall_ready", {31'b0, req_ready}, 32'd0);
        end

        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;

        if (exp_err == 4'd0 && op == 2'b01) begin
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mdl[addr][b*8 +: 8] = wdata[b*8 +: 8];
        end
        if (exp_err != 4'd0 && mdl_errcnt < 255) mdl_errcnt++;

        check("post_hs_valid", {31'b0, rsp_valid}, 32'd0);
        check("post_hs_ready", {31'b0, req_ready}, 32'd1);
        check("err_count",     {24'b0, err_count}, 32'(mdl_errcnt));
    endtask

    initial begin
        logic [1:0]  rop;
        logic [7:0]  raddr;
        int          r;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_addr  = 8'h00;
        req_wdata = 32'h0;
        req_wstrb = 4'h0;
        rsp_ready = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_error", {28'b0, rsp_error}, 32'h0);
        check("rst_err_count", {24'b0, err_count}, 32'h0);
        reset = 1'b1;
        #1;
        check("ready_after_rst", {31'b0, req_ready}, 32'd1);

        // ID register
        do_req(2'b10, 8'd0, 32'h0, 4'h0, 0);
        check("id_read", last_rdata, 32'hACC0_0001);

        // byte-enable write then read back
        do_req(2'b01, 8'd5, 32'h1234_5678, 4'b0101, 0);
        do_req(2'b10, 8'd5, 32'h0, 4'h0, 0);
        check("wstrb_read", last_rdata, 32'h0034_0078);

        // error cases
        do_req(2'b10, 8'd255, 32'h0, 4'h0, 0);
        check("bad_addr_err", {28'b0, last_err}, 32'd1);
        do_req(2'b11, 8'd255, 32'h0, 4'h0, 0);
        check("bad_op_err", {28'b0, last_err}, 32'd2);
        do_req(2'b01, 8'd0, 32'hFFFF_FFFF, 4'hF, 0);
        check("ro_write_err", {28'b0, last_err}, 32'd3);
        do_req(2'b10, 8'd0, 32'h0, 4'h0, 0);
        check("id_after_ro_wr", last_rdata, 32'hACC0_0001);

        // empty-strobe write is a no-op; NOP returns zero
        do_req(2'b01, 8'd7, 32'hDEAD_BEEF, 4'h0, 0);
        do_req(2'b10, 8'd7, 32'h0, 4'h0, 0);
        do_req(2'b00, 8'd7, 32'hDEAD_BEEF, 4'hF, 0);

        // back-pressure
        do_req(2'b01, 8'd10, 32'hCAFE_F00D, 4'hF, 10);
        do_req(2'b10, 8'd10, 32'h0, 4'h0, 10);
        check("bp_read", last_rdata, 32'hCAFE_F00D);

        // random traffic
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      rop = 2'b00;
            else if (r < 5)  rop = 2'b01;
            else if (r < 9)  rop = 2'b10;
            else             rop = 2'b11;
            if ($urandom_range(0, 3) == 0) raddr = 8'($urandom_range(0, 255));
            else                           raddr = 8'($urandom_range(0, 15));
            do_req(rop, raddr, $urandom, 4'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
        end

        // read immediately after write to the same address
        for (int i = 0; i < 20; i++) begin
            raddr = 8'($urandom_range(1, 254));
            do_req(2'b01, raddr, $urandom, 4'($urandom_range(0, 15)), 0);
            do_req(2'b10, raddr, 32'h0, 4'h0, 0);
        end

        // error counter saturation
        for (int i = 0; i < 300; i++)
            do_req(2'b11, 8'($urandom_range(0, 255)), 32'h0, 4'h0, 0);
        check("err_sat", {24'b0, err_count}, 32'd255);

        // reset while in RESP
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_addr  = 8'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_valid", {31'b0, rsp_valid}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_resp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_resp_errcnt", {24'b0, err_count}, 32'd0);
        check("rst_resp_rdata", rsp_rdata, 32'h0);
        check("rst_resp_ready", {31'b0, req_ready}, 32'd0);
        reset = 1'b1;
        model_reset();

        // reset while in ACCESS of a write
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_addr  = 8'd20;
        req_wdata = 32'h5555_AAAA;
        req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_acc_valid", {31'b0, rsp_valid}, 32'd0);
        reset = 1'b1;
        #1;
        do_req(2'b10, 8'd20, 32'h0, 4'h0, 0);
        check("rst_acc_nowrite", last_rdata, 32'h0);
        do_req(2'b10, 8'd10, 32'h0, 4'h0, 0);
        check("rst_cleared", last_rdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_ctrl.md
REG_FILE_CTRL -- requirements
Module: reg_file_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 8, request address width.
REQ-003 SHALL have parameter DEPTH, default 255, number of implemented registers (DEPTH <= 2**ADDR_W).
REQ-004 SHALL have parameter RO_COUNT, default 1, registers 0..RO_COUNT-1 read-only.
REQ-005 SHALL have parameter ID_VALUE, default 32'hACC0_0001, constant returned by register 0.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_ready  output  1  block can accept a request.
REQ-010 SHALL have port req_op  input  2  opcode: 00 NOP, 01 WRITE, 10 READ, 11 reserved.
REQ-011 SHALL have port req_addr  input  ADDR_W  register address.
REQ-012 SHALL have port req_wdata  input  DATA_W  write data.
REQ-013 SHALL have port req_wstrb  input  DATA_W/8  byte enables for WRITE.
REQ-014 SHALL have port rsp_valid  output  1  response present.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-016 SHALL have port rsp_rdata  output  DATA_W  read data.
REQ-017 SHALL have port rsp_error  output  4  error code of this response.
REQ-018 SHALL have port err_count  output  8  saturating count of error responses.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready=1 only in IDLE.
REQ-020 Request SHALL be accepted on a cycle with req_valid && req_ready; op/addr/wdata/wstrb captured; IDLE->ACCESS.
REQ-021 ACCESS SHALL last exactly one cycle (storage read/write), then ->RESP.
REQ-022 In RESP, rsp_valid=1 with rsp_rdata/rsp_error held stable until rsp_valid && rsp_ready; then ->IDLE.
REQ-023 Latency: request accepted in cycle N yields rsp_valid in cycle N+2; max throughput one request per 3 cycles.
REQ-024 Every accepted request, including NOP, SHALL produce exactly one response.
REQ-025 Error codes: 0 OK, 1 invalid address (addr >= DEPTH), 2 invalid opcode (11), 3 write to read-only; priority 2 > 1 > 3.
REQ-026 Any error SHALL suppress the write; rsp_rdata SHALL be 0 on error, on WRITE and on NOP (never X).
REQ-027 READ of address 0 SHALL return ID_VALUE; READ of other read-only addresses SHALL return 0.
REQ-028 WRITE SHALL update only bytes whose req_wstrb bit is 1; wstrb all-zero is a legal OK no-op.
REQ-029 READ in the transaction immediately after a WRITE to the same address SHALL return the new data.
REQ-030 err_count SHALL increment by 1 on each response handshake with rsp_error != 0, saturating at 255.

Reset
REQ-031 When reset=0 at a rising clk edge: FSM->IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, err_count=0, all writable registers=0.
REQ-032 Reset mid-operation (ACCESS or RESP) SHALL discard the pending response without partial write completion beyond that cycle.
REQ-033 req_ready SHALL be 0 while reset=0 and 1 in the first cycle after reset deasserts.

Structure
REQ-034 Shared package reg_file_pkg SHALL hold the opcode enum (OP_NOP, OP_WRITE, OP_READ, OP_RSVD), error-code constants and the FSM state typedef.
REQ-035 Storage SHALL be a sub-module reg_file_array (DEPTH x DATA_W, byte-enable write, one-cycle registered read).

Verification
REQ-036 After reset, READ addr 0 -> rsp_rdata=32'hACC0_0001, rsp_error=0, rsp_valid two cycles after acceptance.
REQ-037 WRITE addr 5 data 32'h1234_5678 wstrb 4'b0101, then READ addr 5 -> rsp_rdata=32'h0034_0078, error 0.
REQ-038 READ addr 255 (DEPTH 255) -> error 1, rdata 0; op 11 with addr 255 -> error 2; WRITE addr 0 -> error 3, addr 0 still reads ID_VALUE.
REQ-039 Hold rsp_ready=0 for 10 cycles -> rsp_valid/rdata/error stable, req_ready=0; request held on req_valid not accepted until handshake.
REQ-040 Issue 300 invalid-opcode requests -> err_count saturates at 255; reset in RESP state -> rsp_valid=0, err_count=0 next cycle.
